sram_data_port: RTL and testbench

Memory-side responder for the pipeline's MEM stage on the DE2 (EP2C35F672C6) board. It accepts the MEM stage's 32-bit word read/write requests (read, write, byte address, write data) and performs them as two 16-bit accesses to the board's asynchronous 256K×16 SRAM. It returns read data, plus a `ready` signal that the pipeline uses to freeze every stage register while an access is in flight.

---
 rtl/sram_data_port_pkg.sv | 17 +
 rtl/sram_data_port_phase_counter.sv | 24 ++
 rtl/sram_data_port.sv | 126 ++++++++++++
 tb/tb_sram_data_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_data_port_pkg.sv
// Shared types and constants for the DE2 SRAM data port: FSM state encoding,
// SRAM bus widths and the default per-phase access length.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int ACCESS_CYCLES_DEF = 2;
    localparam int CNT_W = 3;

endpackage

// File: rtl/sram_data_port_phase_counter.sv
// Phase counter for one 16-bit SRAM phase: counts 0..MAX-1 while enabled,
// flags the terminal count, and clears synchronously.
module sram_phase_counter #(
    parameter int MAX = 2,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = en && (count == W'(MAX - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/sram_data_port.sv
// 32-bit MEM-stage port onto the DE2 256Kx16 async SRAM, done as two 16-bit phases.
// Optional one-word read-hit tag enabled with `define SRAM_READ_HIT_EN.
module sram_data_port
    import sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read,
    input  logic                   write,
    input  logic [15:0]            address,
    input  logic [31:0]            writedata,
    output logic [31:0]            readdata,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    state_t                 state;
    logic [13:0]            word_q;
    logic [31:0]            wdata_q;
    logic                   is_wr_q;
    logic [SRAM_DATA_W-1:0] lo_q;
    logic [CNT_W-1:0]       cnt;
    logic                   tc;
    logic                   busy;
    logic                   req;
    logic                   hit;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^address[1:0];
    assign req  = read | write;
    assign busy = (state == LO) || (state == HI);

    sram_phase_counter #(
        .MAX (ACCESS_CYCLES),
        .W   (CNT_W)
    ) u_phase (
        .clk   (clk),
        .rst   (rst),
        .clr   (~busy | tc),
        .en    (busy),
        .count (cnt),
        .tc    (tc)
    );

`ifdef SRAM_READ_HIT_EN
    logic        tag_vld;
    logic [13:0] tag;

    assign hit = (state == IDLE) && read && !write && tag_vld && (tag == address[15:2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= 1'b0;
            tag     <= '0;
        end else if (state == HI && tc && !is_wr_q) begin
            tag_vld <= 1'b1;
            tag     <= word_q;
        end else if (state == IDLE && write && tag == address[15:2]) begin
            tag_vld <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Request fields are latched at start so a misbehaving master cannot
    // change the address or data mid-sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_q   <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            lo_q     <= '0;
            readdata <= '0;
        end else begin
            case (state)
                IDLE: if (req && !hit) begin
                    state   <= LO;
                    word_q  <= address[15:2];
                    wdata_q <= writedata;
                    is_wr_q <= write;
                end
                LO: if (tc) begin
                    lo_q  <= SRAM_DQ;
                    state <= HI;
                end
                HI: if (tc) begin
                    if (!is_wr_q)
                        readdata <= {SRAM_DQ, lo_q};
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = ~req | hit;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_ADDR = busy ? {2'b00, word_q, (state == HI)} : '0;
    // WE stays high on count 0 so the address is settled before the strobe.
    assign SRAM_WE_N = ~(busy && is_wr_q && (cnt != '0));
    assign SRAM_OE_N = ~(busy && !is_wr_q);
    assign SRAM_DQ   = (busy && is_wr_q) ? ((state == HI) ? wdata_q[31:16] : wdata_q[15:0])
                                         : 'z;

endmodule

// File: tb/tb_sram_data_port.sv
// Bench for sram_data_port: SRAM behavioural model, word-level reference
// model, directed vector table, random traffic and a reset-in-HI sequence.
module tb_sram_data_port;

    localparam int AC = 2;
    localparam int F  = 2 * AC + 1;
`ifdef SRAM_READ_HIT_EN
    localparam bit HIT = 1'b1;
`else
    localparam bit HIT = 1'b0;
`endif
    localparam int HIT_F = HIT ? 0 : F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read = 1'b0, write = 1'b0;
    logic [15:0] address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    sram_data_port #(.ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .ready(ready), .SRAM_DQ(SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 clk = ~clk;

    // Async SRAM: drives on OE low, writes while WE is low.
    logic [15:0] mem [0:32767];
    assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[14:0]] : 16'hzzzz;
    always @(negedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[14:0]] = SRAM_DQ;

    // Word-level reference.
    bit [31:0] ref_mem [0:16383];
    bit [31:0] ref_last;
    bit        ref_tag_v;
    bit [13:0] ref_tag;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic ref_apply(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] wd,
                             output int efr, output logic [31:0] erd);
        bit [13:0] w;
        w = a[15:2];
        if (wr) begin
            ref_mem[w] = wd;
            if (ref_tag == w) ref_tag_v = 1'b0;
            efr = F;
        end else begin
            efr = (HIT && ref_tag_v && ref_tag == w) ? 0 : F;
            ref_last  = ref_mem[w];
            ref_tag   = w;
            ref_tag_v = 1'b1;
        end
        erd = ref_last;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        read = 1'b0; write = 1'b0;
    endtask

    // One transaction: request applied at a negedge, ready polled each cycle,
    // bus pins compared against the expected phase timing every frozen cycle.
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] wd,
                          output int freeze, output logic [31:0] rdat, output bit bus_ok);
        int k;
        bit hi;
        int c;
        logic [17:0] ea;
        bus_ok = 1'b1;
        @(negedge clk);
        read = rd; write = wr; address = a; writedata = wd;
        #1;
        k = 0;
        while (!ready && k < 64) begin
            if (k == 0) begin
                if (!SRAM_WE_N || !SRAM_OE_N) bus_ok = 1'b0;
            end else begin
                hi = (k > AC);
                c  = (k - 1) % AC;
                ea = {2'b00, a[15:2], hi};
                if (SRAM_ADDR !== ea || SRAM_CE_N || SRAM_UB_N || SRAM_LB_N) bus_ok = 1'b0;
                if (wr) begin
                    if (SRAM_OE_N !== 1'b1 || SRAM_WE_N !== (c == 0)) bus_ok = 1'b0;
                    if (SRAM_DQ !== (hi ? wd[31:16] : wd[15:0])) bus_ok = 1'b0;
                end else if (SRAM_OE_N !== 1'b0 || SRAM_WE_N !== 1'b1) begin
                    bus_ok = 1'b0;
                end
            end
            @(negedge clk); #1;
            k++;
        end
        if (!SRAM_WE_N || !SRAM_OE_N) bus_ok = 1'b0;
        freeze = k;
        rdat   = readdata;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_freeze;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int fr, efr;
        logic [31:0] rdat, erd;
        bit ok;
        for (int i = 0; i < 32768; i++) mem[i] = '0;

        vecs[0] = '{0, 1, 16'h0404, 32'h12345678, 32'h00000000, F};
        vecs[1] = '{1, 0, 16'h0404, 32'h0,        32'h12345678, F};
        vecs[2] = '{1, 0, 16'h0404, 32'h0,        32'h12345678, HIT_F};
        vecs[3] = '{0, 1, 16'h0407, 32'hDEADBEEF, 32'h12345678, F};
        vecs[4] = '{1, 0, 16'h0404, 32'h0,        32'hDEADBEEF, F};
        vecs[5] = '{1, 1, 16'h0010, 32'hCAFEF00D, 32'hDEADBEEF, F};
        vecs[6] = '{1, 0, 16'h0010, 32'h0,        32'hCAFEF00D, F};
        vecs[7] = '{0, 1, 16'h0004, 32'hA5A55A5A, 32'hCAFEF00D, F};
        vecs[8] = '{1, 0, 16'h0000, 32'h0,        32'h00000000, F};
        vecs[9] = '{1, 0, 16'h0004, 32'h0,        32'hA5A55A5A, F};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_ready", {31'b0, ready}, 32'h1);
        check("rst_we_oe", {30'b0, SRAM_WE_N, SRAM_OE_N}, 32'h3);
        check("rst_addr", {14'b0, SRAM_ADDR}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, fr, rdat, ok);
            ref_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, efr, erd);
            check($sformatf("vec%0d_freeze", i), fr, vecs[i].exp_freeze);
            check($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
            check($sformatf("vec%0d_bus", i), {31'b0, ok}, 32'h1);
        end
        idle_bus();
        @(negedge clk); #1;
        check("idle_ready", {31'b0, ready}, 32'h1);

        // Random traffic over 16 words
        for (int i = 0; i < 40; i++) begin
            bit rd, wr;
            logic [15:0] a;
            logic [31:0] wd;
            rd = 1'($urandom);
            wr = ($urandom_range(0, 2) == 0);
            if (!rd && !wr) rd = 1'b1;
            a  = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            wd = $urandom;
            do_req(rd, wr, a, wd, fr, rdat, ok);
            ref_apply(rd, wr, a, wd, efr, erd);
            check($sformatf("rnd%0d_freeze", i), fr, efr);
            check($sformatf("rnd%0d_rdata", i), rdat, erd);
            check($sformatf("rnd%0d_bus", i), {31'b0, ok}, 32'h1);
            if ($urandom_range(0, 3) == 0) idle_bus();
        end
        idle_bus();

        // Reset during the first HI cycle of a write to 0x0100
        @(negedge clk);
        write = 1'b1; address = 16'h0100; writedata = 32'h11112222;
        repeat (AC + 1) @(negedge clk);
        rst = 1'b1; write = 1'b0;
        @(negedge clk); #1;
        check("hirst_we", {31'b0, SRAM_WE_N}, 32'h1);
        check("hirst_oe", {31'b0, SRAM_OE_N}, 32'h1);
        check("hirst_addr", {14'b0, SRAM_ADDR}, 32'h0);
        check("hirst_readdata", readdata, 32'h0);
        check("hirst_ready", {31'b0, ready}, 32'h1);
        rst = 1'b0;
        ref_mem[14'h0040][15:0] = 16'h2222;
        ref_last  = '0;
        ref_tag_v = 1'b0;
        do_req(1'b1, 1'b0, 16'h0100, 32'h0, fr, rdat, ok);
        ref_apply(1'b1, 1'b0, 16'h0100, 32'h0, efr, erd);
        check("hirst_reread_freeze", fr, F);
        check("hirst_reread_rdata", rdat, 32'h00002222);
        check("hirst_reread_bus", {31'b0, ok}, 32'h1);
        idle_bus();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
